// File: rtl/myproject_acc_pkg.sv
// Shared definitions for the accumulate/requantize stage.
//   - default width constants for the product, accumulator and output paths
//   - FSM state type for the accumulator controller
//   - clog2 helper used for width checks and counter sizing
package myproject_acc_pkg;

    localparam int unsigned PROD_WIDTH = 26;
    localparam int unsigned ACC_WIDTH  = 32;
    localparam int unsigned OUT_WIDTH  = 16;
    localparam int unsigned SHIFT      = 10;

    typedef enum logic [0:0] {
        ACCUM,
        EMIT
    } acc_state_e;

    // Ceiling log2; clog2(1) = 0. Bounded loop so it stays elaboration-friendly.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Round-half-up, arithmetic right shift and saturate to the output width.
// Ports:
//   sum      in  ACC_WIDTH  signed accumulated value
//   out_data out OUT_WIDTH  signed requantized value
//   out_sat  out 1          value was clipped to the output range
module myproject_round_sat #(
    parameter int unsigned ACC_WIDTH = myproject_acc_pkg::ACC_WIDTH,
    parameter int unsigned OUT_WIDTH = myproject_acc_pkg::OUT_WIDTH,
    parameter int unsigned SHIFT     = myproject_acc_pkg::SHIFT
) (
    input  logic [ACC_WIDTH-1:0] sum,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int unsigned XW = ACC_WIDTH + 1;
    localparam logic signed [XW-1:0] HALF    = XW'(longint'(1) <<< (SHIFT - 1));
    localparam logic signed [XW-1:0] OUT_MAX = XW'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] OUT_MIN = XW'(-(longint'(1) <<< (OUT_WIDTH - 1)));

    logic signed [XW-1:0] sum_ext;
    logic signed [XW-1:0] rounded;

    always_comb begin
        sum_ext = $signed({sum[ACC_WIDTH-1], sum}) + HALF;
        rounded = sum_ext >>> SHIFT;
        if (rounded > OUT_MAX) begin
            out_data = OUT_MAX[OUT_WIDTH-1:0];
            out_sat  = 1'b1;
        end else if (rounded < OUT_MIN) begin
            out_data = OUT_MIN[OUT_WIDTH-1:0];
            out_sat  = 1'b1;
        end else begin
            out_data = rounded[OUT_WIDTH-1:0];
            out_sat  = 1'b0;
        end
    end

endmodule

// File: rtl/myproject_acc_requant.sv
// Dot-product accumulator with requantization.
// Sums N_TERMS signed products, rounds/saturates the sum and presents one result per vector.
// Ports:
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   prod_data/valid/ready   product input handshake (prod_ready depends on out_ready in EMIT)
//   out_data/valid/ready    registered result output handshake
//   out_sat                 result was clipped; qualified by out_valid
module myproject_acc_requant #(
    parameter int unsigned PROD_WIDTH = myproject_acc_pkg::PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = myproject_acc_pkg::ACC_WIDTH,
    parameter int unsigned OUT_WIDTH  = myproject_acc_pkg::OUT_WIDTH,
    parameter int unsigned N_TERMS    = 8,
    parameter int unsigned SHIFT      = myproject_acc_pkg::SHIFT
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat
);

    import myproject_acc_pkg::*;

    localparam int unsigned CNT_WIDTH = clog2(N_TERMS);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N_TERMS - 1);

    if (ACC_WIDTH < PROD_WIDTH + clog2(N_TERMS)) begin : g_bad_acc_width
        $error("ACC_WIDTH too narrow for PROD_WIDTH and N_TERMS");
    end
    if (N_TERMS < 2) begin : g_bad_n_terms
        $error("N_TERMS must be at least 2");
    end
    if (SHIFT < 1) begin : g_bad_shift
        $error("SHIFT must be at least 1");
    end

    acc_state_e             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_sat_q, out_sat_d;

    logic [ACC_WIDTH-1:0]   prod_sext;
    logic [ACC_WIDTH-1:0]   sum;
    logic [OUT_WIDTH-1:0]   rs_data;
    logic                   rs_sat;

    assign prod_sext = {{(ACC_WIDTH - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    // First term of a vector starts from zero, so a stale accumulator never leaks in.
    assign sum = ((cnt_q == '0) ? '0 : acc_q) + prod_sext;

    myproject_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_round_sat (
        .sum      (sum),
        .out_data (rs_data),
        .out_sat  (rs_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;
        prod_ready  = 1'b1;
        case (state_q)
            ACCUM: begin
                prod_ready = 1'b1;
                if (prod_valid) begin
                    acc_d = sum;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d       = '0;
                        out_data_d  = rs_data;
                        out_sat_d   = rs_sat;
                        out_valid_d = 1'b1;
                        state_d     = EMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            EMIT: begin
                // Result and next vector's first term can move in the same cycle.
                prod_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                    if (prod_valid) begin
                        acc_d = prod_sext;
                        cnt_d = CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_myproject_acc_requant.sv
// Self-checking bench for myproject_acc_requant with default parameters.
module tb_myproject_acc_requant;

    localparam int N  = 8;
    localparam int SH = 10;
    localparam longint OMAX = 32767;
    localparam longint OMIN = -32768;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [25:0] prod_data = '0;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sat;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          acc_cyc[$];
    logic [15:0] got_data[$];
    logic        got_sat[$];
    int          got_cyc[$];

    myproject_acc_requant dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sat    (out_sat)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Log every handshake with the cycle it happened on.
    always @(posedge ap_clk) begin
        if (ap_rst_n) begin
            if (prod_valid && prod_ready) acc_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_sat.push_back(out_sat);
                got_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer sum, +half then floor-divide by 2^SH, clamp to 16 bits.
    function automatic void model(input longint vec[N], output logic [15:0] d, output logic s);
        longint sum;
        longint r;
        longint q;
        sum = 0;
        for (int i = 0; i < N; i++) sum += vec[i];
        r = sum + (longint'(1) << (SH - 1));
        if (r >= 0) q = r / (longint'(1) << SH);
        else        q = -((-r + (longint'(1) << SH) - 1) / (longint'(1) << SH));
        if (q > OMAX)      begin d = 16'(OMAX); s = 1'b1; end
        else if (q < OMIN) begin d = 16'(OMIN); s = 1'b1; end
        else               begin d = 16'(q);    s = 1'b0; end
    endfunction

    task automatic clear_logs();
        acc_cyc.delete();
        got_data.delete();
        got_sat.delete();
        got_cyc.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic put(input longint d, output bit ok);
        int n;
        n = 0;
        prod_valid = 1'b1;
        prod_data  = d[25:0];
        #1;
        while (!prod_ready && n < 50) begin
            @(negedge ap_clk);
            #1;
            n++;
        end
        ok = prod_ready;
        @(negedge ap_clk);
    endtask

    task automatic send_vector(input longint vec[N], output bit ok);
        bit one;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            put(vec[i], one);
            ok &= one;
        end
        prod_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (got_data.size() < n && k < 100) begin
            @(negedge ap_clk);
            k++;
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", out_data); end
        checks++;
        if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", out_sat); end
        checks++;
        if (prod_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", prod_ready); end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_basic();
        longint vec[N];
        bit ok;
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) vec[i] = 1024;
        send_vector(vec, ok);
        wait_results(1);
        checks++;
        if (!ok || got_data.size() != 1) begin
            errors++;
            $display("FAIL basic_count: got %0d results want 1 (accept ok=%0b)", got_data.size(), ok);
        end else begin
            checks++;
            if (got_data[0] !== 16'd8) begin errors++; $display("FAIL basic_data: got %0d want 8", $signed(got_data[0])); end
            checks++;
            if (got_sat[0] !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b want 0", got_sat[0]); end
            checks++;
            if (got_cyc[0] - acc_cyc[N-1] != 1) begin
                errors++;
                $display("FAIL basic_latency: got %0d cycles want 1", got_cyc[0] - acc_cyc[N-1]);
            end
        end
    endtask

    task automatic test_rounding();
        longint lasts[4];
        logic [15:0] want[4];
        longint vec[N];
        bit ok;
        lasts[0] = 1536;  want[0] = 16'd2;
        lasts[1] = -1536; want[1] = 16'hFFFF;
        lasts[2] = 511;   want[2] = 16'd0;
        lasts[3] = 512;   want[3] = 16'd1;
        for (int t = 0; t < 4; t++) begin
            clear_logs();
            for (int i = 0; i < N - 1; i++) vec[i] = 0;
            vec[N-1] = lasts[t];
            send_vector(vec, ok);
            wait_results(1);
            checks++;
            if (!ok || got_data.size() != 1) begin
                errors++;
                $display("FAIL round_count[%0d]: got %0d results want 1", t, got_data.size());
            end else if (got_data[0] !== want[t] || got_sat[0] !== 1'b0) begin
                errors++;
                $display("FAIL round[%0d]: got %0d sat %b want %0d sat 0", lasts[t],
                         $signed(got_data[0]), got_sat[0], $signed(want[t]));
            end
        end
    endtask

    task automatic test_saturation();
        longint vals[2];
        logic [15:0] want[2];
        longint vec[N];
        bit ok;
        vals[0] = 33554431;  want[0] = 16'h7FFF;
        vals[1] = -33554432; want[1] = 16'h8000;
        for (int t = 0; t < 2; t++) begin
            clear_logs();
            for (int i = 0; i < N; i++) vec[i] = vals[t];
            send_vector(vec, ok);
            wait_results(1);
            checks++;
            if (!ok || got_data.size() != 1) begin
                errors++;
                $display("FAIL sat_count[%0d]: got %0d results want 1", t, got_data.size());
            end else if (got_data[0] !== want[t] || got_sat[0] !== 1'b1) begin
                errors++;
                $display("FAIL sat[%0d]: got %0d sat %b want %0d sat 1", t,
                         $signed(got_data[0]), got_sat[0], $signed(want[t]));
            end
        end
    endtask

    task automatic test_backpressure();
        longint vec[N];
        longint vec2[N];
        logic [15:0] exp_d, exp2_d;
        logic exp_s, exp2_s;
        bit ok, ok2;
        clear_logs();
        for (int i = 0; i < N; i++) vec[i] = longint'($urandom_range(0, 400000)) - 200000;
        for (int i = 0; i < N; i++) vec2[i] = longint'($urandom_range(0, 400000)) - 200000;
        model(vec, exp_d, exp_s);
        model(vec2, exp2_d, exp2_s);
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) put(vec[i], ok);
        // Offer the next vector's first term while the result is stalled.
        prod_valid = 1'b1;
        prod_data  = vec2[0][25:0];
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s || prod_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: got valid %b data %0d sat %b ready %b want 1 %0d %b 0", k,
                         out_valid, $signed(out_data), out_sat, prod_ready, $signed(exp_d), exp_s);
            end
            @(negedge ap_clk);
        end
        checks++;
        if (acc_cyc.size() != N) begin
            errors++;
            $display("FAIL stall_accepts: got %0d want %0d", acc_cyc.size(), N);
        end
        out_ready = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (got_data.size() != 1 || acc_cyc.size() != N + 1) begin
            errors++;
            $display("FAIL release: got %0d results %0d accepts want 1 and %0d",
                     got_data.size(), acc_cyc.size(), N + 1);
        end else begin
            checks++;
            if (got_data[0] !== exp_d || got_cyc[0] != acc_cyc[N]) begin
                errors++;
                $display("FAIL release_data: got %0d at %0d want %0d at %0d", $signed(got_data[0]),
                         got_cyc[0], $signed(exp_d), acc_cyc[N]);
            end
        end
        ok2 = 1'b1;
        for (int i = 1; i < N; i++) begin
            put(vec2[i], ok);
            ok2 &= ok;
        end
        prod_valid = 1'b0;
        wait_results(2);
        checks++;
        if (!ok2 || got_data.size() != 2) begin
            errors++;
            $display("FAIL bp_second_count: got %0d want 2", got_data.size());
        end else if (got_data[1] !== exp2_d || got_sat[1] !== exp2_s) begin
            errors++;
            $display("FAIL bp_second: got %0d want %0d", $signed(got_data[1]), $signed(exp2_d));
        end
    endtask

    task automatic test_back_to_back();
        bit ok, all_ok;
        clear_logs();
        out_ready = 1'b1;
        all_ok = 1'b1;
        for (int i = 0; i < 3 * N; i++) begin
            put(1024, ok);
            all_ok &= ok;
        end
        prod_valid = 1'b0;
        wait_results(3);
        checks++;
        if (!all_ok || got_data.size() != 3 || acc_cyc.size() != 3 * N) begin
            errors++;
            $display("FAIL b2b_count: got %0d results %0d accepts want 3 and %0d",
                     got_data.size(), acc_cyc.size(), 3 * N);
        end else begin
            checks++;
            if (acc_cyc[3*N-1] - acc_cyc[0] != 3 * N - 1) begin
                errors++;
                $display("FAIL b2b_gaps: got span %0d want %0d", acc_cyc[3*N-1] - acc_cyc[0], 3 * N - 1);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got_data[k] !== 16'd8 || got_cyc[k] - acc_cyc[0] != N * (k + 1)) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got %0d at +%0d want 8 at +%0d", k,
                             $signed(got_data[k]), got_cyc[k] - acc_cyc[0], N * (k + 1));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        longint vec[N];
        bit ok;
        clear_logs();
        for (int i = 0; i < 3; i++) put(5000, ok);
        prod_valid = 1'b0;
        ap_rst_n   = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got valid %b data %h sat %b want 0 0000 0",
                     out_valid, out_data, out_sat);
        end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        clear_logs();
        for (int i = 0; i < N; i++) vec[i] = 1024;
        send_vector(vec, ok);
        wait_results(1);
        repeat (3) @(negedge ap_clk);
        checks++;
        if (!ok || got_data.size() != 1) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d results want 1", got_data.size());
        end else if (got_data[0] !== 16'd8) begin
            errors++;
            $display("FAIL mid_reset_data: got %0d want 8", $signed(got_data[0]));
        end
    endtask

    task automatic test_random();
        longint vec[N];
        logic [15:0] exp_d[$];
        logic exp_s[$];
        logic [15:0] d;
        logic s;
        logic [25:0] raw;
        bit ok, all_ok;
        int mode;
        clear_logs();
        all_ok = 1'b1;
        for (int v = 0; v < 20; v++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                raw = 26'($urandom);
                if (mode == 0)      vec[i] = longint'($urandom_range(0, 6000)) - 3000;
                else if (mode == 1) vec[i] = longint'($signed(raw));
                else                vec[i] = (i == N - 1) ? 512 * longint'($urandom_range(0, 8)) - 2048 : 0;
            end
            model(vec, d, s);
            exp_d.push_back(d);
            exp_s.push_back(s);
            out_ready = 1'b1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    prod_valid = 1'b0;
                    @(negedge ap_clk);
                end
                put(vec[i], ok);
                all_ok &= ok;
            end
            prod_valid = 1'b0;
            out_ready  = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge ap_clk);
            out_ready = 1'b1;
            wait_results(v + 1);
        end
        checks++;
        if (!all_ok || got_data.size() != 20) begin
            errors++;
            $display("FAIL rand_count: got %0d results want 20", got_data.size());
        end else begin
            for (int v = 0; v < 20; v++) begin
                checks++;
                if (got_data[v] !== exp_d[v] || got_sat[v] !== exp_s[v]) begin
                    errors++;
                    $display("FAIL rand[%0d]: got %0d sat %b want %0d sat %b", v,
                             $signed(got_data[v]), got_sat[v], $signed(exp_d[v]), exp_s[v]);
                end
            end
        end
    endtask

    initial begin
        @(negedge ap_clk);
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
